// File: rtl/serial_adder_ctrl_if.sv
// Requester-side handshake and operand bus for serial_adder_ctrl.
// The sub select only exists when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused over WIDTH bits,
// LSB first, one bit per clock, framed by a start/busy/done handshake.
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds the sub select; a-b via
// inverted b and forced carry-in).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one bit per cycle through the adder cell, cnt counts bits
// DONE  | one-cycle done strobe, sum/cout valid, then back to IDLE
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_ctrl_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  // The bit shifted out of the bottom of the result register is never read,
  // so only the upper WIDTH-1 result bits are stored.
  logic [WIDTH-2:0] sr_q, sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             s_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] sr_shift;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    sr_d      = sr_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;

    s_bit     = sa_q[0] ^ sb_q[0] ^ carry_q;
    carry_nxt = (sa_q[0] & sb_q[0]) | (sb_q[0] & carry_q) | (sa_q[0] & carry_q);
    sr_shift  = {s_bit, sr_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          carry_d = bus.cin;
`ifdef SERIAL_ADDER_SUB_EN
          if (bus.sub) begin
            sb_d    = ~bus.b;
            carry_d = 1'b1;
          end
`endif
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d    = {1'b0, sa_q[WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[WIDTH-1:1]};
        carry_d = carry_nxt;
        sr_d    = sr_shift[WIDTH-1:1];
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the full result; cnt holds so it never wraps.
          sum_d   = sr_shift;
          cout_d  = carry_nxt;
          state_d = DONE_ST;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE_ST);
  end

  // All state and outputs registered; asynchronous reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;
  int   cyc  = 0;
`ifdef SERIAL_ADDER_SUB_EN
  logic sub_sel = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();
  serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = sub_sel;
`endif
  endtask

  // One operation from IDLE. hold_* is the previous result that must stay
  // visible until done. Done is expected in the cycle after edge E_W.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] hold_sum, input logic hold_cout,
                        input logic [7:0] exp_sum, input logic exp_cout, input int repulse_at);
    int n;
    int busy_cnt;
    bit got;
    drive(a, b, cin);
    bus.start = 1'b1;
    tick;                               // accepting edge E0
    bus.start = 1'b0;
    busy_cnt = 0;
    got = 0;
    n = 0;
    chk({tag, "/busy_after_e0"}, 32'(bus.busy), 32'd1);
    if (bus.busy) busy_cnt++;
    while (!got && n < 20) begin
      if (n == repulse_at) begin
        bus.start = 1'b1;
        drive(8'h55, 8'h22, 1'b0);
      end else begin
        bus.start = 1'b0;
      end
      tick;
      n++;
      if (bus.busy) busy_cnt++;
      if (bus.done) got = 1;
      else begin
        chk({tag, "/sum_hold"}, 32'(bus.sum), 32'(hold_sum));
        chk({tag, "/cout_hold"}, 32'(bus.cout), 32'(hold_cout));
      end
    end
    bus.start = 1'b0;
    chk({tag, "/done_latency"}, 32'(n), 32'(W));
    chk({tag, "/sum"}, 32'(bus.sum), 32'(exp_sum));
    chk({tag, "/cout"}, 32'(bus.cout), 32'(exp_cout));
    tick;
    chk({tag, "/done_one_cycle"}, 32'(bus.done), 32'd0);
    chk({tag, "/busy_fall"}, 32'(bus.busy), 32'd0);
    chk({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
  endtask

  initial begin
    int extra_done;
    int ndone;
    int t [3];
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic       tc [3];
    logic [7:0] es [3];
    logic       ec [3];

    rst = 1'b1;
    bus.start = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub_sel = 1'b0;
`endif
    drive(8'h00, 8'h00, 1'b0);
    tick;
    tick;
    chk("reset/busy", 32'(bus.busy), 32'd0);
    chk("reset/done", 32'(bus.done), 32'd0);
    chk("reset/sum",  32'(bus.sum),  32'd0);
    chk("reset/cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;
    tick;

    run_op("add_0f_01",   8'h0F, 8'h01, 1'b0, 8'h00, 1'b0, 8'h10, 1'b0, -1);
    run_op("add_ff_01",   8'hFF, 8'h01, 1'b0, 8'h10, 1'b0, 8'h00, 1'b1, -1);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b1, -1);

    // Start re-pulsed during RUN must be ignored: one result, one done.
    run_op("repulse",     8'h20, 8'h0A, 1'b1, 8'hFF, 1'b1, 8'h2B, 1'b0, 3);
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (bus.done) extra_done++;
    end
    chk("repulse/no_extra_done", 32'(extra_done), 32'd0);
    chk("repulse/sum_kept", 32'(bus.sum), 32'h2B);

    // Reset in the middle of RUN clears outputs without waiting for clk.
    drive(8'h3C, 8'h0F, 1'b0);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    #2 rst = 1'b1;
    #1;
    chk("midrst/busy", 32'(bus.busy), 32'd0);
    chk("midrst/done", 32'(bus.done), 32'd0);
    chk("midrst/sum",  32'(bus.sum),  32'd0);
    chk("midrst/cout", 32'(bus.cout), 32'd0);
    tick;
    chk("midrst/busy_held", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    run_op("after_rst",   8'h01, 8'h02, 1'b0, 8'h00, 1'b0, 8'h03, 1'b0, -1);

    // start tied high: back-to-back operations, done every W+2 cycles.
    ta = '{8'h12, 8'h80, 8'hA5};
    tb = '{8'h34, 8'h80, 8'h5A};
    tc = '{1'b0,  1'b1,  1'b0};
    es = '{8'h46, 8'h01, 8'hFF};
    ec = '{1'b0,  1'b1,  1'b0};
    ndone = 0;
    drive(ta[0], tb[0], tc[0]);
    bus.start = 1'b1;
    for (int i = 0; i < 60 && ndone < 3; i++) begin
      tick;
      if (bus.done) begin
        t[ndone] = cyc;
        chk("b2b/sum",  32'(bus.sum),  32'(es[ndone]));
        chk("b2b/cout", 32'(bus.cout), 32'(ec[ndone]));
        ndone++;
        if (ndone < 3) drive(ta[ndone], tb[ndone], tc[ndone]);
        else bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("b2b/done_count", 32'(ndone), 32'd3);
    if (ndone == 3) begin
      chk("b2b/spacing_1", 32'(t[1] - t[0]), 32'(W + 2));
      chk("b2b/spacing_2", 32'(t[2] - t[1]), 32'(W + 2));
    end
    tick;
    tick;

`ifdef SERIAL_ADDER_SUB_EN
    sub_sel = 1'b1;
    run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 8'hFF, 1'b0, 8'hFE, 1'b0, -1);
    run_op("sub_07_05", 8'h07, 8'h05, 1'b0, 8'hFE, 1'b0, 8'h02, 1'b1, -1);
    sub_sel = 1'b0;
    run_op("sub0_add",  8'h07, 8'h05, 1'b0, 8'h02, 1'b1, 8'h0C, 1'b0, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
